// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences a down-counting timer through a
// prescaler, detects terminal count, and supports one-shot or auto-reload
// operation with start/stop/hold control, a terminal-count pulse and a
// sticky interrupt with acknowledge.
//
// Control inputs are plain levels sampled on every rising edge; there is no
// valid/ready handshake. start is acted on only in IDLE or DONE, stop only
// in a non-IDLE state, and stop always wins over start in the same cycle.
module interval_timer_ctrl #(
    parameter int WIDTH = 4,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             irq,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [PS_W-1:0]  ps_cnt;
    logic [WIDTH-1:0] reload_shadow;
    logic [PS_W-1:0]  ps_shadow;
    logic             mode_shadow;

    logic start_ok;
    logic tick;
    logic terminal;

    // Decode accepted start, prescaler tick and terminal-count events.
    always_comb begin
        start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && start && !stop;
        tick     = (state == ST_RUN) && !stop && !hold && (ps_cnt == ps_shadow);
        terminal = tick && (count == '0);
    end

    // Main state, counter, prescaler and shadow register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count         <= '0;
            ps_cnt        <= '0;
            reload_shadow <= '0;
            ps_shadow     <= '0;
            mode_shadow   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (stop && (state == ST_DONE)) begin
                        state  <= ST_IDLE;
                        count  <= '0;
                        ps_cnt <= '0;
                    end else if (start_ok) begin
                        count         <= load_val;
                        reload_shadow <= load_val;
                        ps_shadow     <= prescale;
                        mode_shadow   <= auto_reload;
                        ps_cnt        <= '0;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        count  <= '0;
                        ps_cnt <= '0;
                    end else if (hold) begin
                        state <= ST_HOLD;
                    end else if (ps_cnt != ps_shadow) begin
                        ps_cnt <= ps_cnt + 1'b1;
                    end else begin
                        ps_cnt <= '0;
                        if (count != '0) begin
                            count <= count - 1'b1;
                        end else if (mode_shadow) begin
                            count <= reload_shadow;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        count  <= '0;
                        ps_cnt <= '0;
                    end else if (!hold) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered terminal-count pulse and sticky interrupt (set beats ack).
    always_ff @(posedge clk) begin
        if (rst) begin
            tc  <= 1'b0;
            irq <= 1'b0;
        end else begin
            tc <= terminal;
            if (terminal) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy      = (state == ST_RUN) || (state == ST_HOLD);
        done      = (state == ST_DONE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Testbench for interval_timer_ctrl: table-driven vectors for one-shot and
// auto-reload sequences, hand-written corner sequences, and a short random
// run, all checked through an expected-value queue.
module tb_interval_timer_ctrl;

  localparam int W = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       hold;
  logic       auto_reload;
  logic [3:0] load_val;
  logic [3:0] prescale;
  logic       irq_ack;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc;
  logic       irq;
  logic [1:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  interval_timer_ctrl #(.WIDTH(4), .PS_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .hold(hold),
    .auto_reload(auto_reload),
    .load_val(load_val),
    .prescale(prescale),
    .irq_ack(irq_ack),
    .count(count),
    .busy(busy),
    .done(done),
    .tc(tc),
    .irq(irq),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass = 0;

  // ---------------- reference model ----------------
  logic [1:0] m_state = S_IDLE;
  logic [3:0] m_count = '0;
  logic [3:0] m_ps = '0;
  logic [3:0] m_rel = '0;
  logic [3:0] m_pss = '0;
  logic       m_mode = 1'b0;
  logic       m_tc = 1'b0;
  logic       m_irq = 1'b0;

  task automatic model_step();
    logic [1:0] ns;
    logic [3:0] nc;
    logic [3:0] np;
    logic       nirq;
    logic       term;
    ns = m_state; nc = m_count; np = m_ps; nirq = m_irq; term = 1'b0;
    if (rst) begin
      ns = S_IDLE; nc = '0; np = '0; nirq = 1'b0;
      m_rel = '0; m_pss = '0; m_mode = 1'b0;
    end else begin
      case (m_state)
        S_IDLE, S_DONE: begin
          if (stop && m_state == S_DONE) begin
            ns = S_IDLE; nc = '0; np = '0;
          end else if (start && !stop) begin
            nc = load_val; m_rel = load_val; m_pss = prescale; m_mode = auto_reload;
            np = '0; ns = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            ns = S_IDLE; nc = '0; np = '0;
          end else if (hold) begin
            ns = S_HOLD;
          end else if (m_ps != m_pss) begin
            np = m_ps + 4'd1;
          end else begin
            np = '0;
            if (m_count != 4'd0) nc = m_count - 4'd1;
            else begin
              term = 1'b1;
              if (m_mode) nc = m_rel;
              else ns = S_DONE;
            end
          end
        end
        default: begin
          if (stop) begin
            ns = S_IDLE; nc = '0; np = '0;
          end else if (!hold) begin
            ns = S_RUN;
          end
        end
      endcase
      if (term) nirq = 1'b1;
      else if (irq_ack) nirq = 1'b0;
    end
    m_state = ns; m_count = nc; m_ps = np; m_tc = term; m_irq = nirq;
  endtask

  function automatic logic [W-1:0] model_pack();
    return {m_count, (m_state == S_RUN || m_state == S_HOLD), (m_state == S_DONE), m_tc, m_irq};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic s, input logic sp, input logic h, input logic ar,
                        input logic [3:0] lv, input logic [3:0] ps, input logic ack);
    start = s; stop = sp; hold = h; auto_reload = ar;
    load_val = lv; prescale = ps; irq_ack = ack;
  endtask

  task automatic idle_in();
    set_in(L, L, L, L, 4'd0, 4'd0, L);
  endtask

  // One clock: push the expectation, advance past the edge, pop and compare.
  task automatic cycle(input string tag, input logic use_tab, input logic [W-1:0] tab_exp);
    logic [W-1:0] got;
    logic [W-1:0] e;
    logic [1:0]   e_state;
    model_step();
    if (use_tab) exp_q.push_back(tab_exp);
    else exp_q.push_back(model_pack());
    e_state = m_state;
    @(posedge clk);
    #1;
    got = {count, busy, done, tc, irq};
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: expected queue empty, got %h", tag, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) $display("FAIL %s: {count,busy,done,tc,irq} got %h expected %h", tag, got, e);
      else n_pass++;
    end
    n_total++;
    if (state_dbg !== e_state) $display("FAIL %s_state: got %0d expected %0d", tag, state_dbg, e_state);
    else n_pass++;
  endtask

  task automatic mcycle(input string tag);
    cycle(tag, 1'b0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       s, sp, h, ar;
    logic [3:0] lv, ps;
    logic       ack;
    logic [3:0] ec;
    logic       eb, ed, et, ei;
  } vec_t;

  vec_t tab[23];

  function automatic vec_t mk(input logic s, input logic sp, input logic h, input logic ar,
                              input logic [3:0] lv, input logic [3:0] ps, input logic ack,
                              input logic [3:0] ec, input logic eb, input logic ed,
                              input logic et, input logic ei);
    vec_t v;
    v.s = s; v.sp = sp; v.h = h; v.ar = ar; v.lv = lv; v.ps = ps; v.ack = ack;
    v.ec = ec; v.eb = eb; v.ed = ed; v.et = et; v.ei = ei;
    return v;
  endfunction

  initial begin
    // one-shot, load 3, prescale 0
    tab[0]  = mk(H, L, L, L, 4'd3, 4'd0, L, 4'd3, H, L, L, L);
    tab[1]  = mk(L, L, L, L, 4'd3, 4'd0, L, 4'd2, H, L, L, L);
    tab[2]  = mk(L, L, L, L, 4'd3, 4'd0, L, 4'd1, H, L, L, L);
    tab[3]  = mk(L, L, L, L, 4'd3, 4'd0, L, 4'd0, H, L, L, L);
    tab[4]  = mk(L, L, L, L, 4'd3, 4'd0, L, 4'd0, L, H, H, H);
    tab[5]  = mk(L, L, L, L, 4'd3, 4'd0, L, 4'd0, L, H, L, H);
    tab[6]  = mk(L, L, L, L, 4'd3, 4'd0, H, 4'd0, L, H, L, L);
    // auto-reload, load 2, prescale 1, restart from DONE
    tab[7]  = mk(H, L, L, H, 4'd2, 4'd1, L, 4'd2, H, L, L, L);
    tab[8]  = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd2, H, L, L, L);
    tab[9]  = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd1, H, L, L, L);
    tab[10] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd1, H, L, L, L);
    tab[11] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd0, H, L, L, L);
    tab[12] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd0, H, L, L, L);
    tab[13] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd2, H, L, H, H);
    tab[14] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd2, H, L, L, H);
    tab[15] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd1, H, L, L, H);
    tab[16] = mk(L, L, L, L, 4'd0, 4'd0, H, 4'd1, H, L, L, L);
    tab[17] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd0, H, L, L, L);
    tab[18] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd0, H, L, L, L);
    tab[19] = mk(L, L, L, L, 4'd0, 4'd0, L, 4'd2, H, L, H, H);
    // start while busy ignored, then stop keeps irq, then ack
    tab[20] = mk(H, L, L, L, 4'd9, 4'd0, L, 4'd2, H, L, L, H);
    tab[21] = mk(L, H, L, L, 4'd0, 4'd0, L, 4'd0, L, L, L, H);
    tab[22] = mk(L, L, L, L, 4'd0, 4'd0, H, 4'd0, L, L, L, L);
  end

  // ---------------- test sequence ----------------
  initial begin
    int guard;
    rst = 1'b1;
    idle_in();
    #1;
    mcycle("reset0");
    mcycle("reset1");
    rst = 1'b0;
    mcycle("idle");

    // table-driven vectors
    for (int i = 0; i < 23; i++) begin
      set_in(tab[i].s, tab[i].sp, tab[i].h, tab[i].ar, tab[i].lv, tab[i].ps, tab[i].ack);
      cycle($sformatf("vec%0d", i), 1'b1, {tab[i].ec, tab[i].eb, tab[i].ed, tab[i].et, tab[i].ei});
    end

    // hold mid-count: load 5, hold for 3 cycles once count reaches 3
    set_in(H, L, L, L, 4'd5, 4'd0, L);
    mcycle("hold_start");
    idle_in();
    guard = 0;
    while (m_count != 4'd3 && guard < 10) begin
      mcycle("hold_pre");
      guard++;
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) mcycle("hold_on");
    hold = 1'b0;
    guard = 0;
    while (m_state != S_DONE && guard < 20) begin
      mcycle("hold_post");
      guard++;
    end
    n_total++;
    if (done !== 1'b1) $display("FAIL hold_reach_done: done got %b expected 1", done);
    else n_pass++;

    // DONE with start and stop together: stop wins
    set_in(H, H, L, L, 4'd6, 4'd0, L);
    mcycle("done_start_stop");

    // stop during RUN: no tc, back to IDLE
    set_in(H, L, L, L, 4'd7, 4'd2, L);
    mcycle("stop_start");
    idle_in();
    load_val = 4'd12;
    for (int i = 0; i < 4; i++) mcycle("stop_run");
    stop = 1'b1;
    mcycle("stop_hit");
    stop = 1'b0;
    for (int i = 0; i < 2; i++) mcycle("stop_after");

    // load 0, prescale 0, auto-reload: tc every RUN cycle; ack with tc keeps irq
    set_in(H, L, L, H, 4'd0, 4'd0, H);
    mcycle("zero_start");
    idle_in();
    for (int i = 0; i < 3; i++) mcycle("zero_run");
    irq_ack = 1'b1;
    mcycle("zero_ack_tc");
    irq_ack = 1'b0;
    mcycle("zero_run2");
    stop = 1'b1;
    mcycle("zero_stop");
    stop = 1'b0;
    irq_ack = 1'b1;
    mcycle("zero_ack");
    irq_ack = 1'b0;

    // reset mid-RUN, then a normal restart
    set_in(H, L, L, L, 4'd4, 4'd0, L);
    mcycle("rst_start");
    idle_in();
    mcycle("rst_run3");
    mcycle("rst_run2");
    rst = 1'b1;
    mcycle("rst_mid");
    rst = 1'b0;
    set_in(H, L, L, L, 4'd1, 4'd0, L);
    mcycle("rst_restart");
    idle_in();
    for (int i = 0; i < 4; i++) mcycle("rst_after");

    // short random run against the model
    for (int i = 0; i < 80; i++) begin
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 2)),
             ($urandom_range(0, 4) == 0));
      mcycle("rand");
    end
    idle_in();

    n_total++;
    if (exp_q.size() != 0) $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
